// File: rtl/fifo_nibble_uart_tx_pkg.sv
// rtl/fifo_nibble_uart_tx_pkg.sv - shared types and sizing helpers for the nibble UART transmitter
package fifo_nibble_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int calc_frame_bits(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

    function automatic int calc_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Sizing at the default build (DATA_W=4, PARITY_EN=1, STOP_BITS=1, CLKS_PER_BIT=16).
    localparam int FRAME_BITS = calc_frame_bits(4, 1, 1);
    localparam int CNT_W      = calc_cnt_w(16);

endpackage

// File: rtl/fifo_nibble_uart_tx_bit_timer.sv
// rtl/fifo_nibble_uart_tx_bit_timer.sv - free-running bit-period down-counter with restart
module fifo_nibble_uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_tick_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    assign bit_tick_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_nibble_uart_tx.sv
// rtl/fifo_nibble_uart_tx.sv - drains a nibble FIFO and sends each word as an async serial frame
module fifo_nibble_uart_tx
    import fifo_nibble_uart_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    output logic              fifo_rd_en_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int              BIT_W     = $clog2(DATA_W + 1);
    localparam int              TIMER_W   = calc_cnt_w(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic            ODD_BIT   = (PARITY_ODD != 0);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              bit_tick;
    logic              restart;

    fifo_nibble_uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (TIMER_W)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .bit_tick_o(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d always carries the level of the bit about to start, so tx_q only moves on bit boundaries.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        restart      = 1'b0;
        fifo_rd_en_o = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (enable_i && !fifo_empty_i && !rst) begin
                    fifo_rd_en_o = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d   = fifo_rd_data_i;
                parity_d  = (^fifo_rd_data_i) ^ ODD_BIT;
                bit_cnt_d = '0;
                restart   = 1'b1;
                tx_d      = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        frame_done_o = 1'b1;
                        bit_cnt_d    = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule
